axi_dma_cmd_gen: RTL and testbench

Command generator that sits directly upstream of the AXI master/slave subsystem (`axi_top`). It accepts one DMA transfer request at a time and splits it into boundary-safe commands. Each command is presented on the `cmd_*` valid/ready interface consumed by the write and read masters. It honours `cmd_abort` and reports completion of each request with a one-cycle status pulse.

---
 rtl/axi_dma_pkg.sv | 31 +++
 rtl/axi_dma_chunk_calc.sv | 44 ++++
 rtl/axi_dma_cmd_gen.sv | 201 ++++++++++++++++++++
 tb/tb_axi_dma_cmd_gen.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_dma_pkg.sv
// ---------------------------------------------------------------------------
// axi_dma_pkg
// Shared definitions for the DMA command generator:
//   - burst_e : AXI burst encodings carried on req_burst / cmd_burst
//   - state_e : command generator FSM states
//   - DMA_MAX_CHUNK : default split boundary in bytes
// ---------------------------------------------------------------------------
package axi_dma_pkg;

    localparam int DMA_MAX_CHUNK = 4096;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10,
        BURST_RSVD  = 2'b11
    } burst_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_CALC  = 2'b01,
        ST_ISSUE = 2'b10,
        ST_DONE  = 2'b11
    } state_e;

    // True for burst types this block refuses to split (WRAP and reserved).
    function automatic logic burst_rejected(input logic [1:0] burst);
        return burst[1];
    endfunction

endpackage

// File: rtl/axi_dma_chunk_calc.sv
// ---------------------------------------------------------------------------
// axi_dma_chunk_calc
// Combinational chunk-size calculation for one command.
//   addr      : current chunk start address
//   remaining : bytes still to be issued for the request
//   burst     : burst type of the request
//   chunk     : bytes to issue in the next command
// INCR chunks stop at the next MAX_CHUNK boundary; FIXED takes everything.
// ---------------------------------------------------------------------------
module axi_dma_chunk_calc
    import axi_dma_pkg::*;
#(
    parameter int AXI_ADDR_WD = 32,
    parameter int MAX_CHUNK   = DMA_MAX_CHUNK
) (
    input  logic [AXI_ADDR_WD-1:0] addr,
    input  logic [AXI_ADDR_WD-1:0] remaining,
    input  logic [1:0]             burst,
    output logic [AXI_ADDR_WD-1:0] chunk
);

    localparam logic [AXI_ADDR_WD-1:0] CHUNK_SZ   = AXI_ADDR_WD'(MAX_CHUNK);
    localparam logic [AXI_ADDR_WD-1:0] CHUNK_MASK = AXI_ADDR_WD'(MAX_CHUNK - 1);

    logic [AXI_ADDR_WD-1:0] room_s;

    // Only low address bits enter the boundary math, so a request running
    // past the top of the address space splits cleanly at address 0.
    always_comb begin
        room_s = CHUNK_SZ - (addr & CHUNK_MASK);
        case (burst)
            BURST_INCR: begin
                if (remaining < room_s) begin
                    chunk = remaining;
                end else begin
                    chunk = room_s;
                end
            end
            BURST_FIXED: chunk = remaining;
            default:     chunk = remaining;
        endcase
    end

endmodule

// File: rtl/axi_dma_cmd_gen.sv
// ---------------------------------------------------------------------------
// axi_dma_cmd_gen
// Accepts one DMA request at a time and splits it into boundary-safe
// commands for the downstream AXI masters.
//   AXI_ACLK / AXI_ARESETN : clock, async active-low reset
//   req_*                  : request handshake and attributes
//   cmd_*                  : command handshake, fields and abort input
//   done_valid / done_err  : one-cycle completion pulse and status
//   busy                   : block is not idle
// All outputs are registered except req_ready and busy (state decodes).
// ---------------------------------------------------------------------------
module axi_dma_cmd_gen
    import axi_dma_pkg::*;
#(
    parameter int AXI_ID_WD   = 2,
    parameter int AXI_ADDR_WD = 32,
    parameter int MAX_CHUNK   = DMA_MAX_CHUNK
) (
    input  logic                   AXI_ACLK,
    input  logic                   AXI_ARESETN,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [AXI_ADDR_WD-1:0] req_addr,
    input  logic [AXI_ADDR_WD-1:0] req_bytes,
    input  logic [AXI_ID_WD-1:0]   req_id,
    input  logic [1:0]             req_burst,
    input  logic [2:0]             req_size,
    output logic                   cmd_valid,
    input  logic                   cmd_ready,
    input  logic                   cmd_abort,
    output logic [AXI_ADDR_WD-1:0] cmd_addr,
    output logic [AXI_ID_WD-1:0]   cmd_id,
    output logic [1:0]             cmd_burst,
    output logic [2:0]             cmd_size,
    output logic [AXI_ADDR_WD-1:0] cmd_len,
    output logic                   done_valid,
    output logic                   done_err,
    output logic                   busy
);

    state_e                 state_q,      state_d;
    logic [AXI_ADDR_WD-1:0] addr_q,       addr_d;
    logic [AXI_ADDR_WD-1:0] rem_q,        rem_d;
    logic [AXI_ID_WD-1:0]   id_q,         id_d;
    logic [1:0]             burst_q,      burst_d;
    logic [2:0]             size_q,       size_d;
    logic                   cmd_valid_q,  cmd_valid_d;
    logic [AXI_ADDR_WD-1:0] cmd_addr_q,   cmd_addr_d;
    logic [AXI_ADDR_WD-1:0] cmd_len_q,    cmd_len_d;
    logic [AXI_ID_WD-1:0]   cmd_id_q,     cmd_id_d;
    logic [1:0]             cmd_burst_q,  cmd_burst_d;
    logic [2:0]             cmd_size_q,   cmd_size_d;
    logic                   done_valid_q, done_valid_d;
    logic                   done_err_q,   done_err_d;
    logic [AXI_ADDR_WD-1:0] chunk_s;

    axi_dma_chunk_calc #(
        .AXI_ADDR_WD (AXI_ADDR_WD),
        .MAX_CHUNK   (MAX_CHUNK)
    ) u_chunk_calc (
        .addr      (addr_q),
        .remaining (rem_q),
        .burst     (burst_q),
        .chunk     (chunk_s)
    );

    // Next-state and next-output logic for the request/command FSM.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        rem_d        = rem_q;
        id_d         = id_q;
        burst_d      = burst_q;
        size_d       = size_q;
        cmd_valid_d  = cmd_valid_q;
        cmd_addr_d   = cmd_addr_q;
        cmd_len_d    = cmd_len_q;
        cmd_id_d     = cmd_id_q;
        cmd_burst_d  = cmd_burst_q;
        cmd_size_d   = cmd_size_q;
        done_valid_d = 1'b0;
        done_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    addr_d  = req_addr;
                    rem_d   = req_bytes;
                    id_d    = req_id;
                    burst_d = req_burst;
                    size_d  = req_size;
                    if (req_bytes == '0) begin
                        state_d      = ST_DONE;
                        done_valid_d = 1'b1;
                        done_err_d   = 1'b0;
                    end else if (burst_rejected(req_burst)) begin
                        state_d      = ST_DONE;
                        done_valid_d = 1'b1;
                        done_err_d   = 1'b1;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cmd_abort) begin
                    state_d      = ST_DONE;
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b1;
                end else begin
                    cmd_valid_d = 1'b1;
                    cmd_addr_d  = addr_q;
                    cmd_len_d   = chunk_s;
                    cmd_id_d    = id_q;
                    cmd_burst_d = burst_q;
                    cmd_size_d  = size_q;
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Abort beats a simultaneous handshake: the chunk is dropped
                // and addr/remaining keep their pre-chunk values.
                if (cmd_abort) begin
                    cmd_valid_d  = 1'b0;
                    state_d      = ST_DONE;
                    done_valid_d = 1'b1;
                    done_err_d   = 1'b1;
                end else if (cmd_ready) begin
                    cmd_valid_d = 1'b0;
                    addr_d      = addr_q + cmd_len_q;
                    rem_d       = rem_q - cmd_len_q;
                    if (rem_q == cmd_len_q) begin
                        state_d      = ST_DONE;
                        done_valid_d = 1'b1;
                        done_err_d   = 1'b0;
                    end else begin
                        state_d = ST_CALC;
                    end
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d     = ST_IDLE;
                cmd_valid_d = 1'b0;
            end
        endcase
    end

    // State and registered outputs; reset drops any command in flight.
    always_ff @(posedge AXI_ACLK or negedge AXI_ARESETN) begin
        if (!AXI_ARESETN) begin
            state_q      <= ST_IDLE;
            addr_q       <= '0;
            rem_q        <= '0;
            id_q         <= '0;
            burst_q      <= 2'b00;
            size_q       <= 3'b000;
            cmd_valid_q  <= 1'b0;
            cmd_addr_q   <= '0;
            cmd_len_q    <= '0;
            cmd_id_q     <= '0;
            cmd_burst_q  <= 2'b00;
            cmd_size_q   <= 3'b000;
            done_valid_q <= 1'b0;
            done_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            rem_q        <= rem_d;
            id_q         <= id_d;
            burst_q      <= burst_d;
            size_q       <= size_d;
            cmd_valid_q  <= cmd_valid_d;
            cmd_addr_q   <= cmd_addr_d;
            cmd_len_q    <= cmd_len_d;
            cmd_id_q     <= cmd_id_d;
            cmd_burst_q  <= cmd_burst_d;
            cmd_size_q   <= cmd_size_d;
            done_valid_q <= done_valid_d;
            done_err_q   <= done_err_d;
        end
    end

    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign cmd_valid  = cmd_valid_q;
    assign cmd_addr   = cmd_addr_q;
    assign cmd_len    = cmd_len_q;
    assign cmd_id     = cmd_id_q;
    assign cmd_burst  = cmd_burst_q;
    assign cmd_size   = cmd_size_q;
    assign done_valid = done_valid_q;
    assign done_err   = done_err_q;

endmodule

// File: tb/tb_axi_dma_cmd_gen.sv
// ---------------------------------------------------------------------------
// tb_axi_dma_cmd_gen
// Directed bench for axi_dma_cmd_gen. Expected commands are queued before
// each request and popped as the DUT presents them. Outputs are sampled on
// the falling edge; negedge k after the accepting edge shows the values
// seen at rising edge k.
// ---------------------------------------------------------------------------
module tb_axi_dma_cmd_gen;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] len;
    } cmd_t;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic [31:0] req_bytes;
    logic [1:0]  req_id;
    logic [1:0]  req_burst;
    logic [2:0]  req_size;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_abort;
    logic [31:0] cmd_addr;
    logic [1:0]  cmd_id;
    logic [1:0]  cmd_burst;
    logic [2:0]  cmd_size;
    logic [31:0] cmd_len;
    logic        done_valid;
    logic        done_err;
    logic        busy;

    int   n_tests = 0;
    int   n_fail  = 0;
    cmd_t exp_q[$];

    axi_dma_cmd_gen dut (
        .AXI_ACLK    (clk),
        .AXI_ARESETN (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_addr    (req_addr),
        .req_bytes   (req_bytes),
        .req_id      (req_id),
        .req_burst   (req_burst),
        .req_size    (req_size),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_abort   (cmd_abort),
        .cmd_addr    (cmd_addr),
        .cmd_id      (cmd_id),
        .cmd_burst   (cmd_burst),
        .cmd_size    (cmd_size),
        .cmd_len     (cmd_len),
        .done_valid  (done_valid),
        .done_err    (done_err),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},  32'(req_ready),  32'd1);
        chk({tag, "_busy"},       32'(busy),       32'd0);
        chk({tag, "_cmd_valid"},  32'(cmd_valid),  32'd0);
        chk({tag, "_done_valid"}, 32'(done_valid), 32'd0);
        chk({tag, "_done_err"},   32'(done_err),   32'd0);
        chk({tag, "_cmd_addr"},   cmd_addr,        32'd0);
        chk({tag, "_cmd_len"},    cmd_len,         32'd0);
        chk({tag, "_cmd_id"},     32'(cmd_id),     32'd0);
        chk({tag, "_cmd_burst"},  32'(cmd_burst),  32'd0);
        chk({tag, "_cmd_size"},   32'(cmd_size),   32'd0);
    endtask

    // Run one request; expected commands must already be in exp_q.
    // stall_idx: command held 5 cycles with cmd_ready low (-1 none).
    // abort_idx: command answered with cmd_abort and cmd_ready together (-1 none).
    // exp_done_k: required done_valid sample index (0 = not checked).
    task automatic do_req(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] burst, input logic [1:0] id, input logic [2:0] size,
                          input logic exp_err, input int stall_idx, input int abort_idx,
                          input int exp_done_k);
        int   idx;
        int   stall;
        bit   got_done;
        bit   hs_prev;
        cmd_t e;
        @(negedge clk);
        chk({tag, "_req_ready_idle"}, 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_addr  = a;
        req_bytes = b;
        req_burst = burst;
        req_id    = id;
        req_size  = size;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        idx      = 0;
        stall    = 0;
        got_done = 1'b0;
        hs_prev  = 1'b0;
        for (int k = 1; k <= 200 && !got_done; k++) begin
            @(negedge clk);
            cmd_ready = 1'b0;
            cmd_abort = 1'b0;
            if (hs_prev) chk({tag, "_cmd_valid_gap"}, 32'(cmd_valid), 32'd0);
            hs_prev = 1'b0;
            if (done_valid) begin
                got_done = 1'b1;
                chk({tag, "_done_err"}, 32'(done_err), 32'(exp_err));
                chk({tag, "_req_ready_during_done"}, 32'(req_ready), 32'd0);
                chk({tag, "_cmds_left"}, 32'(exp_q.size()), 32'd0);
                if (exp_done_k > 0) chk({tag, "_done_latency"}, 32'(k), 32'(exp_done_k));
            end else if (cmd_valid) begin
                if (exp_q.size() == 0) begin
                    chk({tag, "_unexpected_cmd"}, 32'd1, 32'd0);
                end else begin
                    e = exp_q[0];
                    chk({tag, "_cmd_addr"},  cmd_addr,        e.addr);
                    chk({tag, "_cmd_len"},   cmd_len,         e.len);
                    chk({tag, "_cmd_id"},    32'(cmd_id),     32'(id));
                    chk({tag, "_cmd_burst"}, 32'(cmd_burst),  32'(burst));
                    chk({tag, "_cmd_size"},  32'(cmd_size),   32'(size));
                    chk({tag, "_busy"},      32'(busy),       32'd1);
                    if (idx == 0) chk({tag, "_first_cmd_latency"}, 32'(k), 32'd2);
                    if (idx == stall_idx && stall < 5) begin
                        stall++;
                    end else begin
                        cmd_ready = 1'b1;
                        if (idx == abort_idx) cmd_abort = 1'b1;
                        void'(exp_q.pop_front());
                        idx++;
                        hs_prev = 1'b1;
                    end
                end
            end
        end
        if (!got_done) chk({tag, "_done_timeout"}, 32'd0, 32'd1);
        @(negedge clk);
        cmd_ready = 1'b0;
        cmd_abort = 1'b0;
        chk({tag, "_req_ready_after"},  32'(req_ready),  32'd1);
        chk({tag, "_done_valid_after"}, 32'(done_valid), 32'd0);
        chk({tag, "_busy_after"},       32'(busy),       32'd0);
    endtask

    initial begin
        bit seen;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_addr  = 32'd0;
        req_bytes = 32'd0;
        req_id    = 2'd0;
        req_burst = 2'b00;
        req_size  = 3'd0;
        cmd_ready = 1'b0;
        cmd_abort = 1'b0;

        // Reset state
        #3;
        chk_reset_outputs("reset");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_reset_outputs("post_reset");

        // Abort while idle is ignored
        cmd_abort = 1'b1;
        @(negedge clk);
        cmd_abort = 1'b0;
        chk("idle_abort_done_valid", 32'(done_valid), 32'd0);
        chk("idle_abort_busy",       32'(busy),       32'd0);

        // Unaligned INCR split
        exp_q.push_back('{32'h0000_0F00, 32'h0000_0100});
        exp_q.push_back('{32'h0000_1000, 32'h0000_0200});
        do_req("unaligned", 32'h0000_0F00, 32'h0000_0300, 2'b01, 2'd1, 3'd2, 1'b0, -1, -1, 0);

        // Aligned multi-chunk with a 5-cycle stall on the second command
        exp_q.push_back('{32'h0000_2000, 32'h0000_1000});
        exp_q.push_back('{32'h0000_3000, 32'h0000_1000});
        do_req("aligned", 32'h0000_2000, 32'h0000_2000, 2'b01, 2'd2, 3'd3, 1'b0, 1, -1, 0);

        // FIXED burst: single command carrying the full length
        exp_q.push_back('{32'h0000_0010, 32'h0000_3000});
        do_req("fixed", 32'h0000_0010, 32'h0000_3000, 2'b00, 2'd3, 3'd1, 1'b0, -1, -1, 0);

        // Rejected bursts and zero length: no commands, done on the next edge
        do_req("wrap",     32'h0000_1000, 32'h0000_0100, 2'b10, 2'd0, 3'd2, 1'b1, -1, -1, 1);
        do_req("reserved", 32'h0000_1000, 32'h0000_0100, 2'b11, 2'd0, 3'd2, 1'b1, -1, -1, 1);
        do_req("zero_len", 32'h0000_1000, 32'h0000_0000, 2'b01, 2'd1, 3'd2, 1'b0, -1, -1, 1);

        // Abort together with cmd_ready on the second chunk
        exp_q.push_back('{32'h0000_2000, 32'h0000_1000});
        exp_q.push_back('{32'h0000_3000, 32'h0000_1000});
        do_req("abort", 32'h0000_2000, 32'h0000_2000, 2'b01, 2'd1, 3'd2, 1'b1, -1, 1, 0);

        // Address wrap across the top of the address space
        exp_q.push_back('{32'hFFFF_FF00, 32'h0000_0100});
        exp_q.push_back('{32'h0000_0000, 32'h0000_0100});
        do_req("addr_wrap", 32'hFFFF_FF00, 32'h0000_0200, 2'b01, 2'd2, 3'd0, 1'b0, -1, -1, 0);

        // Reset asserted while a command is being offered
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 32'hFFFF_FF00;
        req_bytes = 32'h0000_0200;
        req_burst = 2'b01;
        req_id    = 2'd3;
        req_size  = 3'd2;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = cmd_valid;
        end
        chk("rst_mid_cmd_seen", 32'(seen), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_mid_no_done", 32'(done_valid), 32'd0);
            chk("rst_mid_no_cmd",  32'(cmd_valid),  32'd0);
        end

        // Recovery after reset
        exp_q.push_back('{32'h0000_0F00, 32'h0000_0100});
        do_req("recover", 32'h0000_0F00, 32'h0000_0100, 2'b01, 2'd0, 3'd1, 1'b0, -1, -1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
